// File: rtl/ccd_pixel_capture.sv
// Receive side of the linear-CCD interface: tracks Master/ICG, samples the ADC once per
// pixel, drops the leading dummy pixels and streams active pixels out of a small FWFT FIFO.
module ccd_pixel_capture #(
    parameter int DATA_W         = 12,
    parameter int MASTER_PER_PIX = 4,
    parameter int SAMPLE_PHASE   = 2,
    parameter int DUMMY_LEAD     = 32,
    parameter int ACTIVE_PIX     = 3648,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              ccd_master,
    input  logic              ccd_icg,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              cap_en,
    input  logic              clr_err,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_first,
    output logic              pix_last,
    output logic              busy,
    output logic              overflow,
    output logic              frame_err
);
    // state | meaning
    // IDLE  | waiting for an ICG rise with cap_en=1
    // ARM   | frame armed, next Master rise is pixel 0 edge 0
    // RUN   | counting Master edges / pixels, sampling and pushing active pixels

    localparam int MW    = (MASTER_PER_PIX > 1) ? $clog2(MASTER_PER_PIX) : 1;
    localparam int TOTAL = DUMMY_LEAD + ACTIVE_PIX;
    localparam int PW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [MW-1:0] M_LAST  = MW'(MASTER_PER_PIX - 1);
    localparam logic [MW-1:0] M_SAMP  = MW'(SAMPLE_PHASE);
    localparam logic [PW-1:0] P_FIRST = PW'(DUMMY_LEAD);
    localparam logic [PW-1:0] P_LAST  = PW'(TOTAL - 1);
    localparam logic [AW:0]   C_FULL  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t          state;
    logic [MW-1:0]   mcnt, mcnt_nx, sel_m;
    logic [PW-1:0]   pcnt, pcnt_nx, sel_p;
    logic [2:0]      master_sh, icg_sh;
    logic            master_rise, icg_rise;
    logic            edge0, run_edge, push, push_first, push_last, frame_end;

    logic [DATA_W+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full, pop, do_wr;

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            master_sh <= '0;
            icg_sh    <= '0;
        end else begin
            master_sh <= {master_sh[1:0], ccd_master};
            icg_sh    <= {icg_sh[1:0], ccd_icg};
        end
    end

    assign master_rise = master_sh[1] & ~master_sh[2];
    assign icg_rise    = icg_sh[1] & ~icg_sh[2];

    always_comb begin
        mcnt_nx = mcnt + 1'b1;
        pcnt_nx = pcnt;
        if (mcnt == M_LAST) begin
            mcnt_nx = '0;
            pcnt_nx = pcnt + 1'b1;
        end
    end

    // An ICG rise coinciding with a Master rise makes that Master rise pixel 0 edge 0.
    always_comb begin
        edge0      = master_rise & ((icg_rise & cap_en) | (state == ARM & ~icg_rise));
        run_edge   = master_rise & ~icg_rise & (state == RUN);
        sel_m      = edge0 ? '0 : mcnt_nx;
        sel_p      = edge0 ? '0 : pcnt_nx;
        push       = (edge0 | run_edge) & (sel_m == M_SAMP) & (sel_p >= P_FIRST);
        push_first = (sel_p == P_FIRST);
        push_last  = (sel_p == P_LAST);
        frame_end  = push & push_last;
    end

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            mcnt  <= '0;
            pcnt  <= '0;
        end else begin
            if (icg_rise) begin
                if (!cap_en)
                    state <= IDLE;
                else if (master_rise)
                    state <= RUN;
                else
                    state <= ARM;
                mcnt <= '0;
                pcnt <= '0;
            end else begin
                case (state)
                    ARM: if (master_rise) begin
                        state <= RUN;
                        mcnt  <= '0;
                        pcnt  <= '0;
                    end
                    RUN: if (master_rise) begin
                        mcnt <= mcnt_nx;
                        pcnt <= pcnt_nx;
                    end
                    default: ;
                endcase
            end
            // A dropped last word still ends the frame.
            if (frame_end)
                state <= IDLE;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= (overflow & ~clr_err) | (push & ~do_wr);
            frame_err <= (frame_err & ~clr_err) | (icg_rise & (state != IDLE));
        end
    end

    assign full  = (count == C_FULL);
    assign pop   = (count != '0) & pix_ready;
    assign do_wr = push & (~full | pop);

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= {push_first, push_last, adc_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign pix_valid = (count != '0);
    assign pix_data  = pix_valid ? mem[rd_ptr][DATA_W-1:0] : '0;
    assign pix_first = pix_valid & mem[rd_ptr][DATA_W+1];
    assign pix_last  = pix_valid & mem[rd_ptr][DATA_W];

endmodule

// File: tb/tb_ccd_pixel_capture.sv
// Directed bench for ccd_pixel_capture with a short frame (2 dummy + 8 active pixels)
// and a 4-entry FIFO; popped words are collected and compared against hand-made tables.
module tb_ccd_pixel_capture;

    logic        clk_50m = 1'b0;
    logic        rst = 1'b0;
    logic        ccd_master = 1'b0;
    logic        ccd_icg = 1'b0;
    logic [11:0] adc_data = '0;
    logic        cap_en = 1'b0;
    logic        clr_err = 1'b0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [11:0] pix_data;
    logic        pix_first;
    logic        pix_last;
    logic        busy;
    logic        overflow;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        first;
        logic        last;
        logic [11:0] data;
    } word_t;

    typedef struct {
        int          pix;
        logic [11:0] data;
        logic        first;
        logic        last;
    } vec_t;

    word_t got_q[$];
    logic  busy_seen = 1'b0;

    ccd_pixel_capture #(
        .DATA_W(12), .MASTER_PER_PIX(4), .SAMPLE_PHASE(2),
        .DUMMY_LEAD(2), .ACTIVE_PIX(8), .FIFO_DEPTH(4)
    ) dut (
        .clk_50m(clk_50m), .rst(rst), .ccd_master(ccd_master), .ccd_icg(ccd_icg),
        .adc_data(adc_data), .cap_en(cap_en), .clr_err(clr_err),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_first(pix_first), .pix_last(pix_last), .busy(busy),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk_50m = ~clk_50m;

    always @(negedge clk_50m) begin
        if (pix_valid && pix_ready)
            got_q.push_back('{first: pix_first, last: pix_last, data: pix_data});
        if (busy)
            busy_seen <= 1'b1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic check_word(input string tag, input int idx, input logic [11:0] d,
                              input logic f, input logic l);
        if (idx >= got_q.size()) begin
            check({tag, " missing word"}, got_q.size(), idx + 1);
        end else begin
            check({tag, " data"}, got_q[idx].data, d);
            check({tag, " first"}, got_q[idx].first, f);
            check({tag, " last"}, got_q[idx].last, l);
        end
    endtask

    task automatic icg_pulse();
        tick(1);
        ccd_icg = 1'b1;
        tick(8);
        ccd_icg = 1'b0;
        tick(8);
    endtask

    // One pixel = 4 Master periods of 24 clk; adc_data tracks the pixel index.
    task automatic master_pixel(input int pix, input bit icg_first);
        for (int e = 0; e < 4; e++) begin
            if (e == 0)
                adc_data = 12'(pix * 16);
            ccd_master = 1'b1;
            if (icg_first && e == 0) begin
                ccd_icg = 1'b1;
                tick(8);
                ccd_icg = 1'b0;
                tick(4);
            end else begin
                tick(12);
            end
            ccd_master = 1'b0;
            tick(12);
        end
    endtask

    task automatic run_frame(input int npix, input bit icg_first);
        for (int p = 0; p < npix; p++)
            master_pixel(p, icg_first && (p == 0));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ccd_master = 1'b0;
        ccd_icg = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(4);
        got_q.delete();
        busy_seen = 1'b0;
    endtask

    task automatic check_full_frame(input string tag, input int base);
        for (int j = 0; j < 8; j++)
            check_word(tag, base + j, 12'((j + 2) * 16), j == 0, j == 7);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{2, 12'h020, 1'b1, 1'b0};
        tbl[1] = '{3, 12'h030, 1'b0, 1'b0};
        tbl[2] = '{4, 12'h040, 1'b0, 1'b0};
        tbl[3] = '{5, 12'h050, 1'b0, 1'b0};
        tbl[4] = '{6, 12'h060, 1'b0, 1'b0};
        tbl[5] = '{7, 12'h070, 1'b0, 1'b0};
        tbl[6] = '{8, 12'h080, 1'b0, 1'b0};
        tbl[7] = '{9, 12'h090, 1'b0, 1'b1};

        // Reset state
        tick(3);
        check("rst pix_valid", pix_valid, 0);
        check("rst pix_data", pix_data, 0);
        check("rst pix_first", pix_first, 0);
        check("rst pix_last", pix_last, 0);
        check("rst busy", busy, 0);
        check("rst overflow", overflow, 0);
        check("rst frame_err", frame_err, 0);

        // Nominal frame
        do_reset();
        pix_ready = 1'b1;
        cap_en = 1'b1;
        icg_pulse();
        check("nom busy armed", busy, 1);
        run_frame(10, 1'b0);
        check("nom busy after last", busy, 0);
        run_frame(2, 1'b0);
        check("nom count", got_q.size(), 8);
        for (int i = 0; i < 8; i++)
            check_word($sformatf("nom pix%0d", tbl[i].pix), i, tbl[i].data, tbl[i].first, tbl[i].last);
        check("nom overflow", overflow, 0);
        check("nom frame_err", frame_err, 0);

        // Backpressure
        do_reset();
        pix_ready = 1'b0;
        cap_en = 1'b1;
        icg_pulse();
        run_frame(10, 1'b0);
        check("bp overflow", overflow, 1);
        check("bp busy", busy, 0);
        check("bp head valid", pix_valid, 1);
        check("bp head data", pix_data, 12'h020);
        check("bp head first", pix_first, 1);
        tick(20);
        check("bp head stable", pix_data, 12'h020);
        pix_ready = 1'b1;
        tick(10);
        check("bp drained count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check_word("bp word", i, 12'((i + 2) * 16), i == 0, 1'b0);
        check("bp valid after drain", pix_valid, 0);
        check("bp overflow held", overflow, 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(1);
        check("bp overflow cleared", overflow, 0);

        // Early ICG after active pixel 3
        do_reset();
        pix_ready = 1'b1;
        cap_en = 1'b1;
        icg_pulse();
        run_frame(6, 1'b0);
        icg_pulse();
        check("early frame_err", frame_err, 1);
        run_frame(10, 1'b0);
        check("early count", got_q.size(), 12);
        for (int i = 0; i < 4; i++)
            check_word("early partial", i, 12'((i + 2) * 16), i == 0, 1'b0);
        check_full_frame("early refill", 4);

        // cap_en=0 at ICG rise
        do_reset();
        pix_ready = 1'b1;
        cap_en = 1'b0;
        icg_pulse();
        run_frame(10, 1'b0);
        check("noarm count", got_q.size(), 0);
        check("noarm busy_seen", busy_seen, 0);
        cap_en = 1'b1;
        icg_pulse();
        run_frame(10, 1'b0);
        check("noarm then armed count", got_q.size(), 8);
        check_full_frame("noarm then armed", 0);

        // Reset mid-frame with 3 words pending
        do_reset();
        pix_ready = 1'b0;
        cap_en = 1'b1;
        icg_pulse();
        run_frame(5, 1'b0);
        check("midrst pending valid", pix_valid, 1);
        adc_data = 12'h050;
        ccd_master = 1'b1;
        tick(6);
        rst = 1'b0;
        #1;
        check("midrst pix_valid", pix_valid, 0);
        check("midrst pix_data", pix_data, 0);
        check("midrst busy", busy, 0);
        check("midrst overflow", overflow, 0);
        check("midrst frame_err", frame_err, 0);
        tick(3);
        rst = 1'b1;
        pix_ready = 1'b1;
        got_q.delete();
        busy_seen = 1'b0;
        tick(6);
        ccd_master = 1'b0;
        tick(12);
        run_frame(10, 1'b0);
        check("midrst no output", got_q.size(), 0);
        check("midrst no busy", busy_seen, 0);
        icg_pulse();
        run_frame(10, 1'b0);
        check("midrst rearm count", got_q.size(), 8);

        // ICG and Master rising together
        do_reset();
        pix_ready = 1'b1;
        cap_en = 1'b1;
        run_frame(12, 1'b1);
        check("simul count", got_q.size(), 8);
        check_full_frame("simul", 0);
        check("simul frame_err", frame_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
